// File: rtl/fifo_pkg.sv
// Shared types for the fifo_sync_flex family: read-mode selector and the
// FWFT output-stage state encoding.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  typedef enum logic {OUT_EMPTY, OUT_VALID} out_state_e;

  // Map the integer FWFT parameter onto the mode enum.
  function automatic fifo_mode_e mode_of(input int unsigned fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage

// File: rtl/fifo_memory.sv
// Simple dual-port storage for the FIFO family.
// Ports: clk_wr/wr_en/wr_addr/wr_data - synchronous write port;
//        clk_rd/rd_en/rd_addr/rd_data - registered read port (rd_data
//        cleared by rst, array contents are never reset).
module fifo_memory #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk_wr,
  input  logic                  clk_rd,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_wr) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost-full/almost-empty thresholds, occupancy count and
// sticky overflow/underflow flags.
// Ports: clk, rst (async, active-high); wr_en/data_in write side;
//        rd_en/data_out read side (rd_en pops in FWFT mode);
//        full, empty, almost_full, almost_empty, count status;
//        af_level/ae_level thresholds; overflow/underflow sticky errors
//        cleared by clr_err.
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  input  logic [ADDR_WIDTH:0]   af_level,
  input  logic [ADDR_WIDTH:0]   ae_level,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam fifo_mode_e  MODE  = mode_of(FWFT);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_nxt;
  logic          wr_acc;
  logic          rd_acc;
  logic          mem_load;
  logic          mem_nonempty;
  out_state_e    state;
  out_state_e    state_nxt;

  // Acceptance, memory read scheduling and output-stage next state.
  always_comb begin
    state_nxt    = state;
    mem_load     = 1'b0;
    wr_acc       = wr_en & ~full;
    rd_acc       = rd_en & ~empty;
    mem_nonempty = (wr_ptr != rd_ptr);
    if (MODE == FIFO_STD) begin
      mem_load = rd_acc;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (mem_nonempty) begin
            mem_load  = 1'b1;
            state_nxt = OUT_VALID;
          end
        end
        OUT_VALID: begin
          // A pop either refills the output stage or leaves it empty.
          if (rd_acc) begin
            if (mem_nonempty) begin
              mem_load = 1'b1;
            end else begin
              state_nxt = OUT_EMPTY;
            end
          end
        end
        default: state_nxt = OUT_EMPTY;
      endcase
    end
    count_nxt = count + PW'(wr_acc) - PW'(rd_acc);
  end

  // Output-stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (mem_load) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count        <= count_nxt;
      full         <= (count_nxt == PW'(DEPTH));
      empty        <= (MODE == FIFO_STD) ? (count_nxt == '0) : (state_nxt == OUT_EMPTY);
      almost_full  <= (count_nxt >= af_level);
      almost_empty <= (count_nxt <= ae_level);
      // A fresh error event outranks a simultaneous clear.
      overflow     <= (wr_en & full) | (overflow & ~clr_err);
      underflow    <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  fifo_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_wr (clk),
    .clk_rd (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(data_in),
    .rd_en  (mem_load),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(data_out)
  );

endmodule
